instr_fetch_stage: RTL and testbench

- Fetch stage directly upstream of the instruction memory and downstream-feeding the decoder.
- Owns the program counter (PC) and drives the word address into the instruction memory, which has a combinational read.
- Captures the returned instruction into an IF/ID pipeline register with a valid/ready handshake toward decode.
- Handles execute-stage redirects (branch/jump), back-pressure stalls, boot sequencing after reset, and a halt on an all-zero instruction word.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/ifid_reg.sv | 78 +++++++
 rtl/instr_fetch_stage.sv | 114 +++++++++++
 tb/tb_instr_fetch_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: opcodes, the halt encoding, fetch FSM states
// and B-type immediate decoding used by the optional FETCH_BTFN_PREDICT_EN predictor.
package riscv_pkg;

    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [31:0] INSTR_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // Sign-extended byte offset of a B-type branch.
    function automatic logic [31:0] b_imm(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load captures a new word, flush drops validity (wins over load).
// The ifid pred_taken bit exists only when FETCH_BTFN_PREDICT_EN is defined.
module ifid_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc4_in,
`ifdef FETCH_BTFN_PREDICT_EN
    input  logic        pred_in,
    output logic        pred,
`endif
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc4
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4_q, pc4_d;
`ifdef FETCH_BTFN_PREDICT_EN
    logic        pred_q, pred_d;
`endif

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
`ifdef FETCH_BTFN_PREDICT_EN
        pred_d  = pred_q;
`endif
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = instr_in;
            pc_d    = pc_in;
            pc4_d   = pc4_in;
`ifdef FETCH_BTFN_PREDICT_EN
            pred_d  = pred_in;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            pc_q    <= 32'h0;
            pc4_q   <= 32'h0;
`ifdef FETCH_BTFN_PREDICT_EN
            pred_q  <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
`ifdef FETCH_BTFN_PREDICT_EN
            pred_q  <= pred_d;
`endif
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;
    assign pc4   = pc4_q;
`ifdef FETCH_BTFN_PREDICT_EN
    assign pred  = pred_q;
`endif

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC and the BOOT/RUN/HALT sequencing, feeds the IF/ID register.
// Define FETCH_BTFN_PREDICT_EN for backward-taken/forward-not-taken branch prediction.
module instr_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    input  logic               id_ready,
    output logic               ifid_valid,
    output logic [31:0]        ifid_instr,
    output logic [31:0]        ifid_pc,
    output logic [31:0]        ifid_pc4,
`ifdef FETCH_BTFN_PREDICT_EN
    output logic               ifid_pred_taken,
`endif
    output logic               fetch_halted,
    output logic               fetch_misalign
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         misalign_q, misalign_d;
    logic         advance;
    logic         load;
    logic         flush;
`ifdef FETCH_BTFN_PREDICT_EN
    logic         pred_taken;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        load       = 1'b0;
        flush      = 1'b0;
`ifdef FETCH_BTFN_PREDICT_EN
        pred_taken = 1'b0;
`endif
        advance    = !ifid_valid || id_ready;

        // Redirects outrank everything except the boot settle cycle.
        if (state_q != BOOT && redirect_valid) begin
            pc_d       = {redirect_target[31:2], 2'b00};
            flush      = 1'b1;
            state_d    = RUN;
            misalign_d = |redirect_target[1:0];
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (advance) begin
                        if (imem_data == INSTR_ZERO) begin
                            flush   = 1'b1;
                            state_d = HALT;
                        end else begin
                            load = 1'b1;
                            pc_d = pc_q + 32'd4;
`ifdef FETCH_BTFN_PREDICT_EN
                            if (imem_data[6:0] == OPC_BRANCH && imem_data[31]) begin
                                pred_taken = 1'b1;
                                pc_d       = pc_q + b_imm(imem_data);
                            end
`endif
                        end
                    end
                end
                HALT: flush = ifid_valid && id_ready;
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    ifid_reg u_ifid_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .flush    (flush),
        .instr_in (imem_data),
        .pc_in    (pc_q),
        .pc4_in   (pc_q + 32'd4),
`ifdef FETCH_BTFN_PREDICT_EN
        .pred_in  (pred_taken),
        .pred     (ifid_pred_taken),
`endif
        .valid    (ifid_valid),
        .instr    (ifid_instr),
        .pc       (ifid_pc),
        .pc4      (ifid_pc4)
    );

    assign imem_addr      = pc_q[IMEM_AW+1:2];
    assign fetch_halted   = (state_q == HALT);
    assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed vector table, corner-case
// sequences, then randomized traffic against a rule-level reference model.
module tb_instr_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic        id_ready = 1'b0;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc4;
   logic        fetch_halted;
   logic        fetch_misalign;
`ifdef FETCH_BTFN_PREDICT_EN
   logic        ifid_pred_taken;
`endif

   logic [31:0] mem [0:1023];

   int total = 0;
   int bad = 0;

   // Instruction memory answers combinationally from the bench-owned array.
   assign imem_data = mem[imem_addr];

   always #5 clk = ~clk;

   instr_fetch_stage dut (
      .clk             (clk),
      .rst             (rst),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .id_ready        (id_ready),
      .ifid_valid      (ifid_valid),
      .ifid_instr      (ifid_instr),
      .ifid_pc         (ifid_pc),
      .ifid_pc4        (ifid_pc4),
`ifdef FETCH_BTFN_PREDICT_EN
      .ifid_pred_taken (ifid_pred_taken),
`endif
      .fetch_halted    (fetch_halted),
      .fetch_misalign  (fetch_misalign)
   );

   typedef struct {
      logic        rv;
      logic [31:0] tgt;
      logic        rdy;
      logic        expValid;
      logic [31:0] expPc;
      logic [31:0] expInstr;
      logic        expHalt;
      logic        expMis;
      logic [9:0]  expAddr;
   } vec_t;

   vec_t vecs[$];

   // Reference model state, expressed as the fetch rules rather than as RTL registers.
   bit          mBoot;
   bit          mHalted;
   bit          mValid;
   bit          mMis;
   bit          mPred;
   logic [31:0] mPc;
   logic [31:0] mOutPc;
   logic [31:0] mOutInstr;

   task automatic addVec(input logic rv, input logic [31:0] tgt, input logic rdy,
                         input logic ev, input logic [31:0] epc, input logic [31:0] einstr,
                         input logic eh, input logic em, input logic [9:0] eaddr);
      vec_t v;
      v.rv = rv; v.tgt = tgt; v.rdy = rdy;
      v.expValid = ev; v.expPc = epc; v.expInstr = einstr;
      v.expHalt = eh; v.expMis = em; v.expAddr = eaddr;
      vecs.push_back(v);
   endtask

   task automatic checkVal(input string tag, input string what,
                           input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s %s got=%h want=%h", tag, what, got, want);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the rising edge.
   task automatic applyStimulus(input logic rv, input logic [31:0] tgt, input logic rdy);
      redirect_valid  = rv;
      redirect_target = tgt;
      id_ready        = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic ev, input logic [31:0] epc,
                              input logic [31:0] einstr, input logic eh, input logic em,
                              input logic [9:0] eaddr);
      checkVal(tag, "valid", {31'b0, ifid_valid}, {31'b0, ev});
      checkVal(tag, "halted", {31'b0, fetch_halted}, {31'b0, eh});
      checkVal(tag, "misalign", {31'b0, fetch_misalign}, {31'b0, em});
      checkVal(tag, "imem_addr", {22'b0, imem_addr}, {22'b0, eaddr});
      if (ev) begin
         checkVal(tag, "pc", ifid_pc, epc);
         checkVal(tag, "instr", ifid_instr, einstr);
         checkVal(tag, "pc4", ifid_pc4, epc + 32'd4);
      end
   endtask

   task automatic doReset();
      rst = 1'b0;
      redirect_valid = 1'b0;
      id_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Apply one clock edge of the fetch rules to the reference model.
   task automatic modelStep(input logic rv, input logic [31:0] tgt, input logic rdy);
      logic [31:0] w;
      int          imm;
      mMis = 0;
      if (mBoot) begin
         mBoot = 0;
      end else if (rv) begin
         mPc     = tgt - (tgt % 4);
         mValid  = 0;
         mHalted = 0;
         mMis    = (tgt % 4) != 0;
      end else if (mHalted) begin
         if (mValid && rdy) mValid = 0;
      end else if (!mValid || rdy) begin
         w = mem[(mPc / 4) % 1024];
         if (w == 0) begin
            mHalted = 1;
            mValid  = 0;
         end else begin
            mValid    = 1;
            mOutInstr = w;
            mOutPc    = mPc;
            mPred     = 0;
            mPc       = mPc + 4;
`ifdef FETCH_BTFN_PREDICT_EN
            if ((w % 128) == 99 && w >= 32'h8000_0000) begin
               imm = -4096 + int'((w >> 7) % 2) * 2048 + int'((w >> 25) % 64) * 32
                     + int'((w >> 8) % 16) * 2;
               mPc   = mOutPc + 32'(imm);
               mPred = 1;
            end
`endif
         end
      end
   endtask

   initial begin
      logic [31:0] w4alt;
      logic [31:0] tgt;
      logic        rv;
      logic        rdy;

      for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0013;
      mem[0] = 32'h0010_0093;
      mem[1] = 32'h0020_0113;
      mem[2] = 32'h0030_0193;
      mem[3] = 32'h0040_0213;
      mem[4] = 32'h0000_0000;
      mem[5] = 32'hFE00_0EE3;
      mem[6] = 32'h0060_0313;
      mem[7] = 32'h0070_0393;
      mem[8] = 32'h0080_0413;
      mem[9] = 32'h0090_0493;

      // Boot, straight-line run into the zero word, halt, restart, stall, flush.
      addVec(0, 0, 1, 0, 0, 0, 0, 0, 10'd0);
      addVec(0, 0, 1, 1, 32'h00, mem[0], 0, 0, 10'd1);
      addVec(0, 0, 1, 1, 32'h04, mem[1], 0, 0, 10'd2);
      addVec(0, 0, 1, 1, 32'h08, mem[2], 0, 0, 10'd3);
      addVec(0, 0, 1, 1, 32'h0C, mem[3], 0, 0, 10'd4);
      addVec(0, 0, 1, 0, 0, 0, 1, 0, 10'd4);
      for (int i = 0; i < 10; i++) addVec(0, 0, logic'(i % 2), 0, 0, 0, 1, 0, 10'd4);
      addVec(1, 32'h0, 1, 0, 0, 0, 0, 0, 10'd0);
      addVec(0, 0, 1, 1, 32'h00, mem[0], 0, 0, 10'd1);
      addVec(0, 0, 1, 1, 32'h04, mem[1], 0, 0, 10'd2);
      for (int i = 0; i < 3; i++) addVec(0, 0, 0, 1, 32'h04, mem[1], 0, 0, 10'd2);
      addVec(0, 0, 1, 1, 32'h08, mem[2], 0, 0, 10'd3);
      addVec(1, 32'h20, 0, 0, 0, 0, 0, 0, 10'd8);
      addVec(0, 0, 0, 1, 32'h20, mem[8], 0, 0, 10'd9);
      addVec(0, 0, 1, 1, 32'h24, mem[9], 0, 0, 10'd10);

      #2 rst = 1'b0;
      #1;
      checkOutput("reset", 0, 0, 0, 0, 0, 10'd0);
      checkVal("reset", "pc_zero", ifid_pc, 32'h0);
      checkVal("reset", "instr_zero", ifid_instr, 32'h0);
      checkVal("reset", "pc4_zero", ifid_pc4, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rv, vecs[i].tgt, vecs[i].rdy);
         checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expPc,
                     vecs[i].expInstr, vecs[i].expHalt, vecs[i].expMis, vecs[i].expAddr);
      end

      // Misaligned redirect into word 4, then the backward branch at 0x14.
      w4alt  = 32'h0050_0293;
      mem[4] = w4alt;
      applyStimulus(1, 32'h13, 1);
      checkOutput("mis_redirect", 0, 0, 0, 0, 1, 10'd4);
      applyStimulus(0, 0, 1);
      checkOutput("mis_first", 1, 32'h10, w4alt, 0, 0, 10'd5);
`ifdef FETCH_BTFN_PREDICT_EN
      applyStimulus(0, 0, 1);
      checkOutput("btfn_branch", 1, 32'h14, mem[5], 0, 0, 10'd4);
      checkVal("btfn_branch", "pred", {31'b0, ifid_pred_taken}, 32'd1);
      applyStimulus(0, 0, 1);
      checkOutput("btfn_target", 1, 32'h10, w4alt, 0, 0, 10'd5);
      checkVal("btfn_target", "pred", {31'b0, ifid_pred_taken}, 32'd0);
`else
      applyStimulus(0, 0, 1);
      checkOutput("seq_branch", 1, 32'h14, mem[5], 0, 0, 10'd6);
      applyStimulus(0, 0, 1);
      checkOutput("seq_after", 1, 32'h18, mem[6], 0, 0, 10'd7);
`endif

      // Reset mid-stall, then a redirect during the boot cycle must be ignored.
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      #2 rst = 1'b0;
      #1;
      checkOutput("reset_mid", 0, 0, 0, 0, 0, 10'd0);
      checkVal("reset_mid", "pc_zero", ifid_pc, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      applyStimulus(1, 32'h40, 1);
      checkOutput("boot_redirect", 0, 0, 0, 0, 0, 10'd0);
      applyStimulus(0, 0, 1);
      checkOutput("boot_first", 1, 32'h00, mem[0], 0, 0, 10'd1);

      // Randomized traffic with occasional halts and redirects near the 2^32 wrap.
      for (int i = 0; i < 1024; i++) mem[i] = ($urandom_range(0, 29) == 0) ? 32'h0 : $urandom;
      doReset();
      mBoot = 1; mHalted = 0; mValid = 0; mMis = 0; mPred = 0;
      mPc = 32'h0; mOutPc = 32'h0; mOutInstr = 32'h0;
      for (int i = 0; i < 3000; i++) begin
         rv  = mHalted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 11) == 0);
         tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
         rdy = ($urandom_range(0, 3) != 0);
         modelStep(rv, tgt, rdy);
         applyStimulus(rv, tgt, rdy);
         checkOutput($sformatf("rnd%0d", i), mValid, mOutPc, mOutInstr, mHalted, mMis,
                     10'((mPc / 4) % 1024));
`ifdef FETCH_BTFN_PREDICT_EN
         if (mValid) checkVal($sformatf("rnd%0d", i), "pred", {31'b0, ifid_pred_taken},
                              {31'b0, mPred});
`endif
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
